// File: rtl/cplx_mul_arbiter.sv
// Two-client complex multiplier built around one shared signed WIDTH x WIDTH
// real multiplier. Requests are arbitrated round-robin. Each accepted request
// runs four multiply/accumulate steps (ac, bd, ad, bc) and then holds its
// result on a valid/ready port until the consumer takes it.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req{0,1}_valid/_ready    request handshake (ready is combinational)
//   req{0,1}_ar/_ai/_br/_bi  signed operands a = ar + ai*i, b = br + bi*i
//   res_valid/res_ready      result handshake
//   res_re/res_im            signed real/imag parts of a*b (OUT_W bits)
//   res_id                   requester that owns the result
//   busy                     high whenever the FSM is not idle
module cplx_mul_arbiter #(
    parameter int unsigned WIDTH = 16,
    localparam int unsigned OUT_W = 2 * WIDTH + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic signed [WIDTH-1:0] req0_ar,
    input  logic signed [WIDTH-1:0] req0_ai,
    input  logic signed [WIDTH-1:0] req0_br,
    input  logic signed [WIDTH-1:0] req0_bi,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic signed [WIDTH-1:0] req1_ar,
    input  logic signed [WIDTH-1:0] req1_ai,
    input  logic signed [WIDTH-1:0] req1_br,
    input  logic signed [WIDTH-1:0] req1_bi,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [OUT_W-1:0] res_re,
    output logic signed [OUT_W-1:0] res_im,
    output logic                    res_id,
    output logic                    busy
);

    typedef enum logic [2:0] {
        IDLE,
        M_AC,
        M_BD,
        M_AD,
        M_BC,
        DONE
    } state_t;

    state_t state, state_next;

    logic grant;
    logic accept;
    logic id;
    logic last_id;

    logic signed [WIDTH-1:0]   op_ar, op_ai, op_br, op_bi;
    logic signed [WIDTH-1:0]   mul_x, mul_y;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [OUT_W-1:0]   prod_ext;
    logic signed [OUT_W-1:0]   acc_re, acc_im;

    // Round-robin choice: sole valid requester, else the one not served last.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_id;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and request handshakes; readys only ever rise in IDLE.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    accept     = 1'b1;
                    req0_ready = ~grant;
                    req1_ready = grant;
                    state_next = M_AC;
                end
            end
            M_AC:    state_next = M_BD;
            M_BD:    state_next = M_AD;
            M_AD:    state_next = M_BC;
            M_BC:    state_next = DONE;
            DONE: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shared multiplier operand select for the current step.
    always_comb begin
        mul_x = op_ar;
        mul_y = op_br;
        case (state)
            M_BD: begin
                mul_x = op_ai;
                mul_y = op_bi;
            end
            M_AD:    mul_y = op_bi;
            M_BC:    mul_x = op_ai;
            default: ;
        endcase
    end

    assign prod     = (2*WIDTH)'(mul_x) * (2*WIDTH)'(mul_y);
    assign prod_ext = {prod[2*WIDTH-1], prod};

    // Operand capture, accumulation and registered result/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_ar     <= '0;
            op_ai     <= '0;
            op_br     <= '0;
            op_bi     <= '0;
            acc_re    <= '0;
            acc_im    <= '0;
            id        <= 1'b0;
            last_id   <= 1'b1;
            res_re    <= '0;
            res_im    <= '0;
            res_id    <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            res_valid <= (state_next == DONE);
            busy      <= (state_next != IDLE);
            if (accept) begin
                id      <= grant;
                last_id <= grant;
                op_ar   <= grant ? req1_ar : req0_ar;
                op_ai   <= grant ? req1_ai : req0_ai;
                op_br   <= grant ? req1_br : req0_br;
                op_bi   <= grant ? req1_bi : req0_bi;
            end
            case (state)
                M_AC: acc_re <= prod_ext;
                M_BD: acc_re <= acc_re - prod_ext;
                M_AD: acc_im <= prod_ext;
                M_BC: begin
                    // Final step lands straight in the result register.
                    acc_im <= acc_im + prod_ext;
                    res_re <= acc_re;
                    res_im <= acc_im + prod_ext;
                    res_id <= id;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cplx_mul_arbiter.sv
// Self-checking bench for cplx_mul_arbiter: two requester drivers push the
// expected result into a scoreboard at acceptance; independent monitors check
// results, latency, stall behaviour and round-robin grant order.
module tb_cplx_mul_arbiter;

    typedef struct {
        logic signed [15:0] ar, ai, br, bi;
        longint re, im;
    } op_t;

    typedef struct {
        longint id, re, im;
        int acc_cyc;
    } exp_t;

    logic clk;
    logic rst;
    logic vld[2];
    logic rdy[2];
    logic signed [15:0] o_ar[2], o_ai[2], o_br[2], o_bi[2];
    logic res_valid, res_ready, res_id, busy;
    logic signed [32:0] res_re, res_im;

    op_t  q[2][$];
    op_t  cur[2];
    exp_t sb[$];
    int   cyc;
    int   n_vec;
    int   n_fail;
    bit   gaps;
    bit   rnd_rdy;
    bit   rdy_set;

    cplx_mul_arbiter #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(vld[0]), .req0_ready(rdy[0]),
        .req0_ar(o_ar[0]), .req0_ai(o_ai[0]), .req0_br(o_br[0]), .req0_bi(o_bi[0]),
        .req1_valid(vld[1]), .req1_ready(rdy[1]),
        .req1_ar(o_ar[1]), .req1_ai(o_ai[1]), .req1_br(o_br[1]), .req1_bi(o_bi[1]),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_re(res_re), .res_im(res_im), .res_id(res_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic op_t mk(input int ar, input int ai, input int br, input int bi,
                               input longint re, input longint im);
        op_t o;
        o.ar = 16'(ar); o.ai = 16'(ai); o.br = 16'(br); o.bi = 16'(bi);
        o.re = re; o.im = im;
        return o;
    endfunction

    function automatic op_t rnd_op();
        op_t o;
        o.ar = 16'($urandom); o.ai = 16'($urandom);
        o.br = 16'($urandom); o.bi = 16'($urandom);
        o.re = longint'(o.ar) * longint'(o.br) - longint'(o.ai) * longint'(o.bi);
        o.im = longint'(o.ar) * longint'(o.bi) + longint'(o.ai) * longint'(o.br);
        return o;
    endfunction

    // Requester n: presents queued operands, holds them until accepted.
    task automatic drive(input int n);
        bit   acc;
        exp_t e;
        vld[n] = 1'b0;
        forever begin
            @(negedge clk);
            acc = 1'b0;
            if (!rst && vld[n] && rdy[n]) begin
                e.id = longint'(n); e.re = cur[n].re; e.im = cur[n].im; e.acc_cyc = cyc;
                sb.push_back(e);
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
            if (acc) vld[n] = 1'b0;
            if (!rst && !vld[n] && q[n].size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
                cur[n] = q[n].pop_front();
                o_ar[n] = cur[n].ar; o_ai[n] = cur[n].ai;
                o_br[n] = cur[n].br; o_bi[n] = cur[n].bi;
                vld[n] = 1'b1;
            end
        end
    endtask

    initial fork
        drive(0);
        drive(1);
    join_none

    // Consumer ready: fixed level or random per cycle.
    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            res_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_set;
        end
    end

    // Result monitor: compares against scoreboard head every valid cycle.
    initial begin : res_mon
        bit prev_v;
        bit hs_prev;
        prev_v = 1'b0;
        hs_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0;
                hs_prev = 1'b0;
                continue;
            end
            if (hs_prev && (vld[0] || vld[1]))
                chk("accept_after_done", longint'(rdy[0] | rdy[1]), 1);
            if (res_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_result", 1, 0);
                end else begin
                    if (!prev_v) chk("latency", longint'(cyc - sb[0].acc_cyc), 5);
                    chk("res_re", longint'(res_re), sb[0].re);
                    chk("res_im", longint'(res_im), sb[0].im);
                    chk("res_id", longint'(res_id), sb[0].id);
                    if (!res_ready) begin
                        chk("busy_stall", longint'(busy), 1);
                        chk("ready_stall", longint'(rdy[0] | rdy[1]), 0);
                    end else begin
                        void'(sb.pop_front());
                    end
                end
            end
            prev_v = res_valid;
            hs_prev = res_valid && res_ready;
        end
    end

    // Arbitration monitor: independent round-robin model.
    initial begin : arb_mon
        bit mlast;
        int g;
        mlast = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                mlast = 1'b1;
                continue;
            end
            if (rdy[0] || rdy[1]) begin
                g = (vld[0] && vld[1]) ? (mlast ? 0 : 1) : (vld[1] ? 1 : 0);
                chk("grant_onehot", longint'(rdy[0] & rdy[1]), 0);
                chk("grant_valid", longint'(vld[g]), 1);
                chk("grant", longint'(rdy[g]), 1);
                mlast = g[0];
            end
        end
    end

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (q[0].size() == 0 && q[1].size() == 0 && !vld[0] && !vld[1] &&
                sb.size() == 0 && !busy) return;
        end
        chk("timeout", 0, 1);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_res_valid"}, longint'(res_valid), 0);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_res_re"}, longint'(res_re), 0);
        chk({tag, "_res_im"}, longint'(res_im), 0);
        chk({tag, "_res_id"}, longint'(res_id), 0);
        chk({tag, "_ready0"}, longint'(rdy[0]), 0);
        chk({tag, "_ready1"}, longint'(rdy[1]), 0);
    endtask

    initial begin : main
        int k;
        rst = 1'b1;
        gaps = 1'b0;
        rnd_rdy = 1'b0;
        rdy_set = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_zero("reset");

        // Contention from reset: both requesters continuously valid.
        q[0].push_back(mk(1, 2, 3, 4, -5, 10));
        q[1].push_back(mk(2, -1, 2, 1, 5, 0));
        q[0].push_back(mk(-7, 3, 2, 5, -29, -29));
        q[1].push_back(mk(10, 0, 0, 1, 0, 10));
        q[0].push_back(mk(100, -200, -3, 4, 500, 1000));
        q[1].push_back(mk(0, 0, 123, -456, 0, 0));
        q[0].push_back(mk(-1, -1, -1, -1, 0, 2));
        q[1].push_back(mk(1000, 1000, 1000, -1000, 2000000, 0));
        @(posedge clk);
        #2;
        rst = 1'b0;
        wait_idle(400);

        // Single ops and extremes.
        q[0].push_back(mk(3, 4, 5, -2, 23, 14));
        wait_idle(100);
        q[1].push_back(mk(-32768, -32768, -32768, -32768, 0, 64'sd2147483648));
        wait_idle(100);
        q[0].push_back(mk(32767, 0, -32768, 0, -1073709056, 0));
        wait_idle(100);

        // Backpressure with a second request pending.
        rdy_set = 1'b0;
        q[0].push_back(mk(-5, 6, 7, -8, 13, 82));
        q[1].push_back(mk(9, 9, -9, 9, -162, 0));
        k = 0;
        while (!res_valid && k < 50) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (!res_valid) chk("bp_timeout", 0, 1);
        repeat (7) @(posedge clk);
        #3;
        rdy_set = 1'b1;
        wait_idle(200);

        // Asynchronous reset during M_BD discards the op.
        q[0].push_back(mk(3, 4, 5, -2, 23, 14));
        k = 0;
        while (sb.size() == 0 && k < 50) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (sb.size() == 0) chk("rst_accept_timeout", 0, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_zero("midop_reset");
        sb.delete();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        q[0].push_back(mk(1, 1, 1, -1, 2, 0));
        q[1].push_back(mk(2, 3, 4, 5, -7, 22));
        wait_idle(200);

        // Random regression.
        gaps = 1'b1;
        rnd_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) q[$urandom_range(0, 1)].push_back(rnd_op());
        wait_idle(40000);
        rnd_rdy = 1'b0;
        gaps = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/cplx_mul_arbiter.md
Name: cplx_mul_arbiter

Overview:
- Shares one signed WIDTH x WIDTH real multiplier between two complex-multiply requesters.
- Arbitrates round-robin and runs four multiply/accumulate steps per request (ac, bd, ad, bc).
- Returns (a+bi)*(c+di) with the winning requester's ID on a valid/ready result port.
- Sits between the complex-number datapath clients and the shared multiplier, replacing per-client full complex multipliers.

Parameters:
- WIDTH, 16, signed width of each real/imag operand part.
- OUT_W, 2*WIDTH+1, signed width of each result part. Fixed by derivation; not to be overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 operands valid.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_ar, req0_ai, req0_br, req0_bi  in  WIDTH each  signed operands: a = ar + ai·i, b = br + bi·i.
- req1_valid, req1_ready, req1_ar, req1_ai, req1_br, req1_bi: same as requester 0.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts the result.
- res_re  out  OUT_W  signed real part of the product.
- res_im  out  OUT_W  signed imag part of the product.
- res_id  out  1  ID of the requester that owns the result.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- FSM states: IDLE, M_AC, M_BD, M_AD, M_BC, DONE.
- Arbitration, IDLE only:
  - grant = the only valid requester.
  - If both are valid, grant the requester not granted last time. Pointer last_id resets to 1, so req0 wins the first contention.
  - reqN_ready = (state==IDLE) && grant==N. Combinational from the valids.
  - Requesters must not make valid depend on ready.
- Accept (valid && ready) at edge T:
  - Operands latched into registers; id latched; last_id <= id; state -> M_AC.
  - Operands are not re-sampled afterwards.
- Sequencing, one shared multiply per cycle, products 2*WIDTH signed, accumulators OUT_W signed with sign extension:
  - M_AC: acc_re = ar*br.
  - M_BD: acc_re -= ai*bi.
  - M_AD: acc_im = ar*bi.
  - M_BC: acc_im += ai*br.
  - Then -> DONE.
- Latency: res_valid rises in the cycle after edge T+4, i.e. 5 cycles after accept.
- DONE:
  - res_valid=1; res_re/res_im/res_id held stable until res_valid && res_ready.
  - On that edge -> IDLE.
  - Next accept is possible at the earliest in the following cycle. Minimum 6 cycles per operation.
- No overflow or saturation. OUT_W holds the full-range result, including (-2^(W-1))^2 * 2 on the imag part.
- Requests not granted stay pending. Requesters hold valid and operands until ready.
- Reset (async, any state, including mid-operation or in DONE with res_valid high):
  - state=IDLE; res_valid=0; res_re=0; res_im=0; res_id=0; busy=0; last_id=1.
  - Accumulators and operand registers cleared.
  - The in-flight operation is discarded; no result is emitted after reset release.
- While res_valid=1 and res_ready=0: busy=1; both reqN_ready=0 regardless of the valids.
- res_ready high outside DONE has no effect.

Test Plan:
- Single op: req0 (3+4i)*(5-2i), res_ready=1 → req0_ready high 1 cycle; res_valid exactly 5 cycles after accept; res_re=23, res_im=14, res_id=0.
- Extremes, WIDTH=16: req1 (-32768-32768i)*(-32768-32768i) → res_re=0, res_im=2147483648 (33-bit positive), res_id=1. Also (32767+0i)*(-32768+0i) → res_re=-1073709056, res_im=0.
- Contention: req0 and req1 valid together continuously after reset, each with distinct operands → grants in order 0,1,0,1; res_id sequence matches; every result correct; no request is starved.
- Backpressure: hold res_ready=0 for 7 cycles in DONE → res_re/res_im/res_id stable; busy=1; both readys 0. Raise res_ready → IDLE next cycle; pending req accepted the cycle after.
- Reset mid-op: assert rst during M_BD → outputs zero immediately (asynchronous); after release no res_valid appears. The next req0 (1+1i)*(1-1i) yields 2+0i, with req0 winning arbitration.
- Random regression, 1000 ops: both requesters with random valids and operands in full signed range, random res_ready → results match a reference model bit-exactly, with ID order consistent with round-robin.
